// File: rtl/pad_in_conditioner_if.sv
// rtl/pad_in_conditioner_if.sv - pad-side inputs, controls and conditioned outputs of pad_in_conditioner
interface pad_in_conditioner_if #(
  parameter int WIDTH    = 32,
  parameter int DB_CNT_W = 8
);
  logic [WIDTH-1:0]    pad_din_i;
  logic [WIDTH-1:0]    pad_ie_i;
  logic [DB_CNT_W-1:0] db_thresh_i;
  logic [WIDTH-1:0]    irq_rise_en_i;
  logic [WIDTH-1:0]    irq_fall_en_i;
  logic [WIDTH-1:0]    irq_clr_i;
  logic [WIDTH-1:0]    gpio_o;
  logic [WIDTH-1:0]    rise_o;
  logic [WIDTH-1:0]    fall_o;
  logic [WIDTH-1:0]    irq_status_o;
  logic                irq_o;

  modport master (
    output pad_din_i, pad_ie_i, db_thresh_i, irq_rise_en_i, irq_fall_en_i, irq_clr_i,
    input  gpio_o, rise_o, fall_o, irq_status_o, irq_o
  );

  modport slave (
    input  pad_din_i, pad_ie_i, db_thresh_i, irq_rise_en_i, irq_fall_en_i, irq_clr_i,
    output gpio_o, rise_o, fall_o, irq_status_o, irq_o
  );
endinterface

// File: rtl/pad_in_conditioner.sv
// rtl/pad_in_conditioner.sv - per-bit mask, synchronise, debounce, edge detect and sticky irq status
module pad_in_conditioner #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 8
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  pad_in_conditioner_if.slave bus
);

  logic [WIDTH-1:0]    masked;
  logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]    sync_out;
  logic [DB_CNT_W-1:0] flip_at;
  logic [DB_CNT_W-1:0] cnt_q [WIDTH];
  logic [DB_CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0]    gpio_q, gpio_d;
  logic [WIDTH-1:0]    rise_q, rise_d;
  logic [WIDTH-1:0]    fall_q, fall_d;
  logic [WIDTH-1:0]    status_q, status_d;
  logic [WIDTH-1:0]    set_vec;
  logic                irq_q;

  assign masked = bus.pad_din_i & bus.pad_ie_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= masked;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // A threshold of 0 is treated as 1, so the flip point never underflows.
  assign flip_at = (bus.db_thresh_i == '0) ? '0 : bus.db_thresh_i - 1'b1;

  always_comb begin
    gpio_d = gpio_q;
    rise_d = '0;
    fall_d = '0;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_d[b] = '0;
      if (sync_out[b] != gpio_q[b]) begin
        if (cnt_q[b] >= flip_at) begin
          gpio_d[b] = sync_out[b];
          rise_d[b] = sync_out[b];
          fall_d[b] = ~sync_out[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Set is OR-ed in after the clear so a simultaneous edge keeps the status bit.
  assign set_vec  = (rise_q & bus.irq_rise_en_i) | (fall_q & bus.irq_fall_en_i);
  assign status_d = (status_q & ~bus.irq_clr_i) | set_vec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
      gpio_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= cnt_d[b];
      gpio_q   <= gpio_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      irq_q    <= |status_d;
    end
  end

  assign bus.gpio_o       = gpio_q;
  assign bus.rise_o       = rise_q;
  assign bus.fall_o       = fall_q;
  assign bus.irq_status_o = status_q;
  assign bus.irq_o        = irq_q;

endmodule

// File: tb/tb_pad_in_conditioner.sv
// tb/tb_pad_in_conditioner.sv - self-checking bench for pad_in_conditioner
module tb_pad_in_conditioner;
  localparam int W    = 32;
  localparam int SYNC = 2;
  localparam int DBW  = 8;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  pad_in_conditioner_if #(.WIDTH(W), .DB_CNT_W(DBW)) bus ();

  pad_in_conditioner #(.WIDTH(W), .SYNC_STAGES(SYNC), .DB_CNT_W(DBW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pad value seen SYNC edges late; output follows once it has disagreed Teff edges in a row.
  logic [W-1:0] pipe[$];
  logic [W-1:0] m_gpio, m_rise, m_fall, m_status;
  logic         m_irq;
  int           run [W];

  task automatic model_reset();
    pipe.delete();
    for (int k = 0; k < SYNC; k++) pipe.push_back('0);
    m_gpio = '0; m_rise = '0; m_fall = '0; m_status = '0; m_irq = 1'b0;
    for (int b = 0; b < W; b++) run[b] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s, nxt;
    int teff;
    s    = pipe[0];
    teff = (bus.db_thresh_i == 0) ? 1 : int'(bus.db_thresh_i);
    nxt  = (m_status & ~bus.irq_clr_i) | (m_rise & bus.irq_rise_en_i) | (m_fall & bus.irq_fall_en_i);
    m_status = nxt;
    m_irq    = (nxt != 0);
    m_rise   = '0;
    m_fall   = '0;
    for (int b = 0; b < W; b++) begin
      if (s[b] != m_gpio[b]) begin
        run[b]++;
        if (run[b] >= teff) begin
          m_gpio[b] = s[b];
          if (s[b]) m_rise[b] = 1'b1; else m_fall[b] = 1'b1;
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
    end
    void'(pipe.pop_front());
    pipe.push_back(bus.pad_din_i & bus.pad_ie_i);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".gpio"},   bus.gpio_o,       m_gpio);
    check({tag, ".rise"},   bus.rise_o,       m_rise);
    check({tag, ".fall"},   bus.fall_o,       m_fall);
    check({tag, ".status"}, bus.irq_status_o, m_status);
    check({tag, ".irq"},    32'(bus.irq_o),   32'(m_irq));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all("model");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    check("reset.gpio_zero", bus.gpio_o, 32'h0);
    check("reset.irq_zero", 32'(bus.irq_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_bit(input int b, input logic val, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.gpio_o[b] !== val && n <= limit);
  endtask

  typedef struct {
    logic [31:0] din;
    logic [7:0]  thr;
    logic [31:0] e_gpio;
    logic [31:0] e_rise;
    logic [31:0] e_fall;
    logic [31:0] e_stat;
    logic        e_irq;
  } vec_t;

  vec_t tbl [16];
  logic [31:0] hist [16];
  int n;

  initial begin
    // Bit 0 qualifies at edge 6 with Teff=4; a 3-cycle pulse on bit 3 must be filtered out.
    for (int i = 0; i < 16; i++) begin
      tbl[i].din    = (i >= 8 && i <= 10) ? 32'h9 : 32'h1;
      tbl[i].thr    = 8'd4;
      tbl[i].e_gpio = (i >= 5) ? 32'h1 : 32'h0;
      tbl[i].e_rise = (i == 5) ? 32'h1 : 32'h0;
      tbl[i].e_fall = 32'h0;
      tbl[i].e_stat = (i >= 6) ? 32'h1 : 32'h0;
      tbl[i].e_irq  = (i >= 6);
    end

    rst_n = 1'b1;
    bus.pad_din_i = '0; bus.pad_ie_i = '1; bus.db_thresh_i = '0;
    bus.irq_rise_en_i = '0; bus.irq_fall_en_i = '0; bus.irq_clr_i = '0;
    model_reset();
    #2;
    do_reset();

    bus.irq_rise_en_i = 32'h1;
    for (int i = 0; i < 16; i++) begin
      bus.pad_din_i   = tbl[i].din;
      bus.db_thresh_i = tbl[i].thr;
      step();
      check($sformatf("tbl%0d.gpio", i),   bus.gpio_o,       tbl[i].e_gpio);
      check($sformatf("tbl%0d.rise", i),   bus.rise_o,       tbl[i].e_rise);
      check($sformatf("tbl%0d.fall", i),   bus.fall_o,       tbl[i].e_fall);
      check($sformatf("tbl%0d.status", i), bus.irq_status_o, tbl[i].e_stat);
      check($sformatf("tbl%0d.irq", i),    32'(bus.irq_o),   32'(tbl[i].e_irq));
    end

    // Threshold 0 and 1 both give a 3-edge latency.
    for (int t = 0; t < 2; t++) begin
      bus.irq_rise_en_i = '0; bus.pad_din_i = '0;
      do_reset();
      bus.db_thresh_i = DBW'(t);
      bus.pad_din_i = 32'h20;
      wait_bit(5, 1'b1, 10, n);
      check($sformatf("thr%0d.latency", t), n, 3);
    end
    for (int j = 0; j < 16; j++) begin
      bus.pad_din_i = bus.pad_din_i ^ 32'h20;
      hist[j] = bus.pad_din_i;
      step();
      if (j >= 2) check($sformatf("toggle%0d", j), 32'(bus.gpio_o[5]), 32'(hist[j-2][5]));
    end

    // Dropping input enable on a high bit is a falling input.
    bus.pad_din_i = '0;
    do_reset();
    bus.db_thresh_i = 8'd2;
    bus.pad_din_i = 32'h80;
    wait_bit(7, 1'b1, 10, n);
    check("ie.rise_latency", n, 4);
    step();
    bus.irq_fall_en_i = 32'h80;
    bus.pad_ie_i = ~32'h80;
    step(); step(); step();
    check("ie.e3_gpio", 32'(bus.gpio_o[7]), 32'h1);
    step();
    check("ie.e4_gpio", 32'(bus.gpio_o[7]), 32'h0);
    check("ie.e4_fall", 32'(bus.fall_o[7]), 32'h1);
    check("ie.e4_irq", 32'(bus.irq_o), 32'h0);
    step();
    check("ie.e5_irq", 32'(bus.irq_o), 32'h1);
    check("ie.e5_status", 32'(bus.irq_status_o[7]), 32'h1);
    bus.pad_ie_i = '1; bus.irq_fall_en_i = '0; bus.pad_din_i = '0;

    // Set beats a simultaneous clear; a lone clear empties status and irq.
    do_reset();
    bus.db_thresh_i = 8'd1;
    bus.irq_rise_en_i = 32'h4; bus.irq_fall_en_i = 32'h4;
    bus.pad_din_i = 32'h4;
    wait_bit(2, 1'b1, 10, n);
    step();
    check("clr.set_first", 32'(bus.irq_status_o[2]), 32'h1);
    bus.pad_din_i = 32'h0;
    wait_bit(2, 1'b0, 10, n);
    check("clr.fall_pulse", 32'(bus.fall_o[2]), 32'h1);
    bus.irq_clr_i = 32'h4;
    step();
    check("clr.set_wins", 32'(bus.irq_status_o[2]), 32'h1);
    bus.irq_clr_i = 32'h0;
    step();
    bus.irq_clr_i = 32'h4;
    step();
    check("clr.cleared", 32'(bus.irq_status_o[2]), 32'h0);
    check("clr.irq_low", 32'(bus.irq_o), 32'h0);
    bus.irq_clr_i = '0; bus.irq_rise_en_i = '0; bus.irq_fall_en_i = '0;

    // Reset in the middle of a debounce count forces full re-qualification.
    bus.pad_din_i = 32'h1; bus.irq_rise_en_i = 32'h1;
    wait_bit(0, 1'b1, 10, n);
    step();
    bus.db_thresh_i = 8'd8;
    bus.pad_din_i = 32'h201;
    step(); step(); step(); step();
    do_reset();
    check("midrst.gpio", bus.gpio_o, 32'h0);
    check("midrst.status", bus.irq_status_o, 32'h0);
    wait_bit(9, 1'b1, 20, n);
    check("midrst.requalify", n, 10);

    // Random traffic against the reference model.
    bus.irq_rise_en_i = $urandom; bus.irq_fall_en_i = $urandom;
    for (int c = 0; c < 3000; c++) begin
      bus.pad_din_i = bus.pad_din_i ^ ($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) bus.db_thresh_i = DBW'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) begin
        bus.irq_rise_en_i = $urandom;
        bus.irq_fall_en_i = $urandom;
      end
      if ($urandom_range(0, 19) == 0) bus.pad_ie_i = $urandom | $urandom;
      else if ($urandom_range(0, 19) == 0) bus.pad_ie_i = '1;
      bus.irq_clr_i = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
